uart_rx_param: RTL and testbench



---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_sampler.sv | 45 ++++
 rtl/uart_rx_param.sv | 166 ++++++++++++++++
 tb/tb_uart_rx_param.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes and receiver states.
// Shared by the receiver and a future transmitter.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sampler.sv
// Input synchroniser and 3-tap majority voter for the UART receiver.
// Ports: BRclk, rst_n, rx (async line), busy, cnt -> rx_s, bit_val, bit_stb.
module uart_rx_sampler #(
  parameter int SYNC_STAGES = 2,
  parameter int OVERSAMPLE  = 16,
  parameter int CW          = $clog2(OVERSAMPLE)
) (
  input  logic          BRclk,
  input  logic          rst_n,
  input  logic          rx,
  input  logic          busy,
  input  logic [CW-1:0] cnt,
  output logic          rx_s,
  output logic          bit_val,
  output logic          bit_stb
);

  localparam logic [CW-1:0] TAP0 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] TAP1 = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] TAP2 = CW'(OVERSAMPLE / 2 + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s0;
  logic                   s1;

  always_ff @(posedge BRclk) begin
    if (!rst_n) begin
      sync <= '1;
      s0   <= 1'b1;
      s1   <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rx};
      if (busy && cnt == TAP0) s0 <= rx_s;
      if (busy && cnt == TAP1) s1 <= rx_s;
    end
  end

  assign rx_s = sync[SYNC_STAGES-1];

  // Third tap is the live synchronised sample, so the vote
  // resolves in the same cycle it is taken.
  assign bit_stb = busy && cnt == TAP2;
  assign bit_val = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver on the oversampling clock BRclk.
// Ports: UART_RX in; RX_DATA/RX_VALID/RX_READY handshake, error flags, OVERRUN, RX_BUSY.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 BRclk,
  input  logic                 rst_n,
  input  logic                 UART_RX,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_VALID,
  input  logic                 RX_READY,
  output logic                 FRAME_ERR,
  output logic                 PARITY_ERR,
  output logic                 OVERRUN,
  output logic                 RX_BUSY
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  // cnt is the phase within a bit; after a resolve at
  // OVERSAMPLE/2+1 it carries on from the next phase.
  localparam logic [CW-1:0] CNT_NEXT = CW'(OVERSAMPLE / 2 + 2);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  localparam bit PAR_ON  = PARITY != PAR_NONE;
  localparam bit PAR_ODDM = PARITY == PAR_ODD;

  rx_state_t            state;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_inc;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 ferr;
  logic                 perr;
  logic                 busy;
  logic                 rx_s;
  logic                 bit_val;
  logic                 bit_stb;

  assign busy    = state != ST_IDLE;
  assign cnt_inc = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;

  uart_rx_sampler #(
    .SYNC_STAGES(SYNC_STAGES),
    .OVERSAMPLE (OVERSAMPLE),
    .CW         (CW)
  ) u_sampler (
    .BRclk  (BRclk),
    .rst_n  (rst_n),
    .rx     (UART_RX),
    .busy   (busy),
    .cnt    (cnt),
    .rx_s   (rx_s),
    .bit_val(bit_val),
    .bit_stb(bit_stb)
  );

  always_ff @(posedge BRclk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bcnt       <= '0;
      shreg      <= '0;
      ferr       <= 1'b0;
      perr       <= 1'b0;
      RX_DATA    <= '0;
      RX_VALID   <= 1'b0;
      FRAME_ERR  <= 1'b0;
      PARITY_ERR <= 1'b0;
      OVERRUN    <= 1'b0;
      RX_BUSY    <= 1'b0;
    end else begin
      OVERRUN <= 1'b0;
      if (RX_VALID && RX_READY) RX_VALID <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state   <= ST_START;
            cnt     <= '0;
            bcnt    <= '0;
            ferr    <= 1'b0;
            perr    <= 1'b0;
            RX_BUSY <= 1'b1;
          end
        end

        ST_START: begin
          cnt <= cnt_inc;
          if (bit_stb) begin
            if (bit_val) begin
              state   <= ST_IDLE;
              RX_BUSY <= 1'b0;
            end else begin
              state <= ST_DATA;
              cnt   <= CNT_NEXT;
            end
          end
        end

        ST_DATA: begin
          cnt <= cnt_inc;
          if (bit_stb) begin
            cnt   <= CNT_NEXT;
            shreg <= {bit_val, shreg[DATA_BITS-1:1]};
            if (bcnt == DATA_LAST) begin
              bcnt  <= '0;
              state <= PAR_ON ? ST_PARITY : ST_STOP;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
        end

        ST_PARITY: begin
          cnt <= cnt_inc;
          if (bit_stb) begin
            cnt   <= CNT_NEXT;
            perr  <= (^shreg ^ bit_val) != PAR_ODDM;
            state <= ST_STOP;
          end
        end

        ST_STOP: begin
          cnt <= cnt_inc;
          if (bit_stb) begin
            cnt <= CNT_NEXT;
            if (!bit_val) ferr <= 1'b1;
            if (bcnt == STOP_LAST) begin
              bcnt    <= '0;
              state   <= ST_IDLE;
              RX_BUSY <= 1'b0;
              // Holding register is free if empty or being
              // drained this very cycle; otherwise drop.
              if (!RX_VALID || RX_READY) begin
                RX_DATA    <= shreg;
                FRAME_ERR  <= ferr | ~bit_val;
                PARITY_ERR <= perr;
                RX_VALID   <= 1'b1;
              end else begin
                OVERRUN <= 1'b1;
              end
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
        end

        default: begin
          state   <= ST_IDLE;
          RX_BUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: four configurations
// (8N1, 8E1, 8O1, 8N2) with a transfer scoreboard.
module tb_uart_rx_param;

  localparam int OS  = 16;
  localparam int SS  = 2;
  localparam int LAT = SS + 1 + (OS / 2 + 1) + 9 * OS + 1;

  localparam int PAR_CFG [4] = '{0, 1, 2, 0};
  localparam int STB_CFG [4] = '{1, 1, 1, 2};

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } rec_t;

  typedef struct {
    int         ch;
    logic [7:0] d;
    logic       pb;
    logic [1:0] st;
    int         gb;
    logic [7:0] xd;
    logic       xfe;
    logic       xpe;
  } vec_t;

  logic       BRclk;
  logic       rst_n;
  logic       rx  [4];
  logic       rdy [4];
  logic [7:0] dat [4];
  logic       vld [4];
  logic       fe  [4];
  logic       pe  [4];
  logic       ovr [4];
  logic       bsy [4];

  int   checks;
  int   errors;
  int   ovr_cnt [4];
  rec_t sb [$];
  rec_t rq [$];
  vec_t tv [12];

  initial BRclk = 1'b0;
  always #5 BRclk = ~BRclk;

  uart_rx_param #(.PARITY(0), .STOP_BITS(1)) u0 (
    .BRclk(BRclk), .rst_n(rst_n), .UART_RX(rx[0]),
    .RX_DATA(dat[0]), .RX_VALID(vld[0]), .RX_READY(rdy[0]),
    .FRAME_ERR(fe[0]), .PARITY_ERR(pe[0]),
    .OVERRUN(ovr[0]), .RX_BUSY(bsy[0]));

  uart_rx_param #(.PARITY(1), .STOP_BITS(1)) u1 (
    .BRclk(BRclk), .rst_n(rst_n), .UART_RX(rx[1]),
    .RX_DATA(dat[1]), .RX_VALID(vld[1]), .RX_READY(rdy[1]),
    .FRAME_ERR(fe[1]), .PARITY_ERR(pe[1]),
    .OVERRUN(ovr[1]), .RX_BUSY(bsy[1]));

  uart_rx_param #(.PARITY(2), .STOP_BITS(1)) u2 (
    .BRclk(BRclk), .rst_n(rst_n), .UART_RX(rx[2]),
    .RX_DATA(dat[2]), .RX_VALID(vld[2]), .RX_READY(rdy[2]),
    .FRAME_ERR(fe[2]), .PARITY_ERR(pe[2]),
    .OVERRUN(ovr[2]), .RX_BUSY(bsy[2]));

  uart_rx_param #(.PARITY(0), .STOP_BITS(2)) u3 (
    .BRclk(BRclk), .rst_n(rst_n), .UART_RX(rx[3]),
    .RX_DATA(dat[3]), .RX_VALID(vld[3]), .RX_READY(rdy[3]),
    .FRAME_ERR(fe[3]), .PARITY_ERR(pe[3]),
    .OVERRUN(ovr[3]), .RX_BUSY(bsy[3]));

  // Transfer monitor: records every accepted word.
  always @(negedge BRclk) begin
    rec_t r;
    if (rst_n === 1'b1) begin
      for (int c = 0; c < 4; c++) begin
        if (vld[c] === 1'b1 && rdy[c] === 1'b1) begin
          r.ch = 2'(c);
          r.d  = dat[c];
          r.fe = fe[c];
          r.pe = pe[c];
          rq.push_back(r);
        end
        if (ovr[c] === 1'b1) ovr_cnt[c]++;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic expect_word(input int ch, input logic [7:0] d,
                             input logic xfe, input logic xpe);
    rec_t r;
    r.ch = 2'(ch);
    r.d  = d;
    r.fe = xfe;
    r.pe = xpe;
    sb.push_back(r);
  endtask

  task automatic check_sb(input string tag);
    rec_t g;
    rec_t e;
    checks++;
    if (rq.size() != sb.size()) begin
      errors++;
      $display("FAIL %s word_count got %0d want %0d",
               tag, rq.size(), sb.size());
    end
    while (rq.size() > 0 && sb.size() > 0) begin
      g = rq.pop_front();
      e = sb.pop_front();
      checks++;
      if (g != e) begin
        errors++;
        $display("FAIL %s word got ch%0d %h fe%0b pe%0b want ch%0d %h fe%0b pe%0b",
                 tag, g.ch, g.d, g.fe, g.pe, e.ch, e.d, e.fe, e.pe);
      end
    end
    rq.delete();
    sb.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge BRclk);
    #1;
  endtask

  // Drives one frame, one value per BRclk, starting just after
  // the next rising edge. gbit flips that frame bit for one tick.
  task automatic send_frame(input int ch, input logic [7:0] d,
                            input logic pbit, input logic [1:0] st,
                            input int gbit);
    logic [15:0] fb;
    int n;
    fb    = '1;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[1+i] = d[i];
    n = 9;
    if (PAR_CFG[ch] != 0) begin
      fb[n] = pbit;
      n++;
    end
    fb[n] = st[0];
    n++;
    if (STB_CFG[ch] == 2) begin
      fb[n] = st[1];
      n++;
    end
    @(posedge BRclk);
    #1;
    for (int b = 0; b < n; b++) begin
      for (int t = 0; t < OS; t++) begin
        rx[ch] = (b == gbit && t == OS / 2) ? ~fb[b] : fb[b];
        @(posedge BRclk);
        #1;
      end
    end
    rx[ch] = 1'b1;
  endtask

  initial begin
    int  k;
    int  base;
    bit  seen;

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    for (int c = 0; c < 4; c++) begin
      rx[c]  = 1'b1;
      rdy[c] = 1'b1;
    end

    tv[0]  = '{0, 8'hA5, 1'b0, 2'b11, -1, 8'hA5, 1'b0, 1'b0};
    tv[1]  = '{1, 8'h3C, 1'b1, 2'b11, -1, 8'h3C, 1'b0, 1'b1};
    tv[2]  = '{1, 8'h3C, 1'b0, 2'b11, -1, 8'h3C, 1'b0, 1'b0};
    tv[3]  = '{2, 8'h3C, 1'b1, 2'b11, -1, 8'h3C, 1'b0, 1'b0};
    tv[4]  = '{2, 8'h3C, 1'b0, 2'b11, -1, 8'h3C, 1'b0, 1'b1};
    tv[5]  = '{0, 8'h55, 1'b0, 2'b11,  1, 8'h55, 1'b0, 1'b0};
    tv[6]  = '{0, 8'h55, 1'b0, 2'b11,  8, 8'h55, 1'b0, 1'b0};
    tv[7]  = '{0, 8'h00, 1'b0, 2'b10, -1, 8'h00, 1'b1, 1'b0};
    tv[8]  = '{3, 8'h5A, 1'b0, 2'b01, -1, 8'h5A, 1'b1, 1'b0};
    tv[9]  = '{3, 8'hC3, 1'b0, 2'b11, -1, 8'hC3, 1'b0, 1'b0};
    tv[10] = '{1, 8'h01, 1'b1, 2'b11, -1, 8'h01, 1'b0, 1'b0};
    tv[11] = '{2, 8'hFF, 1'b0, 2'b11, -1, 8'hFF, 1'b0, 1'b1};

    // Reset state
    idle(3);
    chk("rst_data",  32'(dat[0]), 32'h0);
    chk("rst_valid", 32'(vld[0]), 32'h0);
    chk("rst_ferr",  32'(fe[0]),  32'h0);
    chk("rst_perr",  32'(pe[0]),  32'h0);
    chk("rst_ovr",   32'(ovr[0]), 32'h0);
    chk("rst_busy",  32'(bsy[0]), 32'h0);
    rst_n = 1'b1;
    idle(5);

    // Latency of 8N1 0xA5 and single-cycle valid pulse
    expect_word(0, 8'hA5, 1'b0, 1'b0);
    k = 0;
    fork
      send_frame(0, 8'hA5, 1'b0, 2'b11, -1);
      begin
        @(posedge BRclk);
        #1;
        while (vld[0] !== 1'b1 && k < 400) begin
          @(posedge BRclk);
          #1;
          k++;
        end
        chk("latency", 32'(k), 32'(LAT));
        @(posedge BRclk);
        #1;
        chk("valid_pulse", 32'(vld[0]), 32'h0);
      end
    join
    idle(30);
    check_sb("latency_a5");

    // Table-driven frames
    for (int i = 0; i < 12; i++) begin
      expect_word(tv[i].ch, tv[i].xd, tv[i].xfe, tv[i].xpe);
      send_frame(tv[i].ch, tv[i].d, tv[i].pb, tv[i].st, tv[i].gb);
      idle(30);
      check_sb($sformatf("vec%0d", i));
    end

    // Short glitch: false start rejected
    seen = 1'b0;
    @(posedge BRclk);
    #1;
    rx[0] = 1'b0;
    repeat (4) @(posedge BRclk);
    #1;
    rx[0] = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if (bsy[0] === 1'b1) seen = 1'b1;
      @(posedge BRclk);
      #1;
    end
    chk("glitch_busy_seen", 32'(seen), 32'h1);
    chk("glitch_busy_end",  32'(bsy[0]), 32'h0);
    check_sb("glitch");

    // Overrun: second word dropped, first held
    rdy[0] = 1'b0;
    expect_word(0, 8'h11, 1'b0, 1'b0);
    send_frame(0, 8'h11, 1'b0, 2'b11, -1);
    idle(10);
    base = ovr_cnt[0];
    send_frame(0, 8'h22, 1'b0, 2'b11, -1);
    idle(10);
    chk("ovr_pulses", 32'(ovr_cnt[0] - base), 32'h1);
    chk("ovr_held",   32'(dat[0]), 32'h11);
    chk("ovr_valid",  32'(vld[0]), 32'h1);
    rdy[0] = 1'b1;
    idle(2);
    chk("ovr_drain", 32'(vld[0]), 32'h0);
    expect_word(0, 8'h33, 1'b0, 1'b0);
    send_frame(0, 8'h33, 1'b0, 2'b11, -1);
    idle(30);
    check_sb("overrun");

    // Ready arrives in the completion cycle: no overrun
    rdy[0] = 1'b0;
    expect_word(0, 8'h44, 1'b0, 1'b0);
    send_frame(0, 8'h44, 1'b0, 2'b11, -1);
    idle(10);
    expect_word(0, 8'h66, 1'b0, 1'b0);
    base = ovr_cnt[0];
    fork
      send_frame(0, 8'h66, 1'b0, 2'b11, -1);
      begin
        @(posedge BRclk);
        repeat (LAT - 1) @(posedge BRclk);
        #1;
        rdy[0] = 1'b1;
      end
    join
    idle(30);
    chk("coincide_ovr", 32'(ovr_cnt[0] - base), 32'h0);
    check_sb("coincide");

    // Reset during data bits drops held word and frame
    rdy[0] = 1'b0;
    send_frame(0, 8'h77, 1'b0, 2'b11, -1);
    idle(10);
    chk("pre_rst_valid", 32'(vld[0]), 32'h1);
    fork
      send_frame(0, 8'hF0, 1'b0, 2'b11, -1);
      begin
        @(posedge BRclk);
        repeat (100) @(posedge BRclk);
        #1;
        rst_n = 1'b0;
        @(posedge BRclk);
        #1;
        rst_n = 1'b1;
        chk("midrst_valid", 32'(vld[0]), 32'h0);
        chk("midrst_data",  32'(dat[0]), 32'h0);
        chk("midrst_busy",  32'(bsy[0]), 32'h0);
        rdy[0] = 1'b1;
      end
    join
    idle(60);
    chk("post_rst_busy", 32'(bsy[0]), 32'h0);
    check_sb("midreset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
